seq_detect_param: RTL and testbench

//  Parametrised serial pattern detector: next generation of the fixed 1101 Mealy detector.

---
 rtl/seq_detect_param.sv | 88 ++++++++
 tb/tb_seq_detect_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector: runtime-loadable PAT_W-bit pattern, overlap/non-overlap, Mealy (same cycle) or Moore (+1 clk) y.
// No backpressure; en qualifies din and gaps in en hold a partial match.
module seq_detect_param #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1101,
  parameter bit               OVERLAP  = 1'b1,
  parameter bit               MOORE    = 1'b0,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-2:0] hist_q;
  logic [FW-1:0]    fill_q;
  logic [PAT_W-1:0] window;
  logic             consume;
  logic             hit;

  assign consume = en & ~pat_load;
  assign window  = {hist_q, din};
  assign hit     = consume & (fill_q == FILL_MAX) & (window == pat_q);

  // fill_q saturates at PAT_W-1: once full, every consumed bit completes a candidate window
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q  <= PAT_INIT;
      hist_q <= '0;
      fill_q <= '0;
    end else if (pat_load) begin
      pat_q  <= pat_in;
      hist_q <= '0;
      fill_q <= '0;
    end else if (en) begin
      if (hit && !OVERLAP) begin
        hist_q <= '0;
        fill_q <= '0;
      end else begin
        hist_q <= window[PAT_W-2:0];
        if (fill_q != FILL_MAX) begin
          fill_q <= fill_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (hit && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
      if (match_cnt == CNT_MAX - 1'b1) begin
        cnt_sat <= 1'b1;
      end
    end
  end

  generate
    if (MOORE) begin : g_moore
      logic y_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          y_q <= 1'b0;
        end else begin
          y_q <= hit;
        end
      end
      assign y = y_q;
    end else begin : g_mealy
      // hit is still evaluated during reset, so gate it off explicitly
      assign y = hit & rst;
    end
  endgenerate

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: six parameter variants share one stimulus stream and are
// checked every cycle against a queue-based window model, plus literal directed expectations.
module tb_seq_detect_param;

  localparam int          NI     = 6;
  localparam int          PW[NI] = '{4, 4, 4, 4, 7, 2};
  localparam int          OV[NI] = '{1, 0, 1, 1, 0, 1};
  localparam int          MO[NI] = '{0, 0, 1, 0, 1, 0};
  localparam int          CW[NI] = '{8, 8, 8, 2, 3, 4};
  localparam logic [15:0] PI[NI] = '{16'hD, 16'hD, 16'hD, 16'hF, 16'h59, 16'h2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, din, pat_load;
  logic [15:0] pin;
  logic        y_w[NI];
  logic        sat_w[NI];
  logic [7:0]  cnt_w[NI];
  logic [7:0]  c0, c1, c2;
  logic [1:0]  c3;
  logic [2:0]  c4;
  logic [3:0]  c5;

  assign cnt_w[0] = c0;
  assign cnt_w[1] = c1;
  assign cnt_w[2] = c2;
  assign cnt_w[3] = {6'b0, c3};
  assign cnt_w[4] = {5'b0, c4};
  assign cnt_w[5] = {4'b0, c5};

  seq_detect_param u0 (.clk(clk), .rst(rst), .en(en), .din(din), .pat_load(pat_load),
                       .pat_in(pin[3:0]), .y(y_w[0]), .match_cnt(c0), .cnt_sat(sat_w[0]));
  seq_detect_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .rst(rst), .en(en), .din(din), .pat_load(pat_load),
                       .pat_in(pin[3:0]), .y(y_w[1]), .match_cnt(c1), .cnt_sat(sat_w[1]));
  seq_detect_param #(.MOORE(1'b1)) u2 (.clk(clk), .rst(rst), .en(en), .din(din), .pat_load(pat_load),
                       .pat_in(pin[3:0]), .y(y_w[2]), .match_cnt(c2), .cnt_sat(sat_w[2]));
  seq_detect_param #(.PAT_INIT(4'b1111), .CNT_W(2)) u3 (.clk(clk), .rst(rst), .en(en), .din(din),
                       .pat_load(pat_load), .pat_in(pin[3:0]), .y(y_w[3]), .match_cnt(c3), .cnt_sat(sat_w[3]));
  seq_detect_param #(.PAT_W(7), .PAT_INIT(7'b1011001), .OVERLAP(1'b0), .MOORE(1'b1), .CNT_W(3)) u4 (
                       .clk(clk), .rst(rst), .en(en), .din(din), .pat_load(pat_load),
                       .pat_in(pin[6:0]), .y(y_w[4]), .match_cnt(c4), .cnt_sat(sat_w[4]));
  seq_detect_param #(.PAT_W(2), .PAT_INIT(2'b10), .CNT_W(4)) u5 (.clk(clk), .rst(rst), .en(en), .din(din),
                       .pat_load(pat_load), .pat_in(pin[1:0]), .y(y_w[5]), .match_cnt(c5), .cnt_sat(sat_w[5]));

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of the last PAT_W-1 consumed bits since the last clear
  bit          mq[NI][$];
  logic [15:0] m_pat[NI];
  int          m_cnt[NI];
  logic        m_sat[NI];
  logic        m_yq[NI];

  always @(negedge clk) begin
    logic h, b;
    int n, mx;
    for (int k = 0; k < NI; k++) begin
      n  = PW[k];
      mx = (1 << CW[k]) - 1;
      h  = 1'b0;
      if (en && !pat_load && mq[k].size() == n - 1) begin
        h = 1'b1;
        for (int j = 0; j < n; j++) begin
          b = (j < n - 1) ? mq[k][j] : din;
          if (b != m_pat[k][n-1-j]) h = 1'b0;
        end
      end
      if (started) begin
        chk($sformatf("y[%0d]", k), 32'(y_w[k]), (MO[k] != 0) ? 32'(m_yq[k]) : 32'(rst & h));
        chk($sformatf("cnt[%0d]", k), 32'(cnt_w[k]), 32'(m_cnt[k]));
        chk($sformatf("sat[%0d]", k), 32'(sat_w[k]), 32'(m_sat[k]));
      end
      if (!rst) begin
        m_pat[k] = PI[k];
        mq[k].delete();
        m_cnt[k] = 0;
        m_sat[k] = 1'b0;
        m_yq[k]  = 1'b0;
      end else begin
        m_yq[k] = h;
        if (pat_load) begin
          m_pat[k] = pin & ((16'h1 << n) - 16'h1);
          mq[k].delete();
        end else if (en) begin
          if (h && OV[k] == 0) begin
            mq[k].delete();
          end else begin
            mq[k].push_back(din);
            if (mq[k].size() > n - 1) b = mq[k].pop_front();
          end
          if (h && m_cnt[k] < mx) m_cnt[k]++;
          if (m_cnt[k] == mx) m_sat[k] = 1'b1;
        end
      end
    end
  end

  logic [31:0] ym[NI];
  logic [31:0] sm3;
  int          cidx;

  task automatic start_rec();
    cidx = 1;
    sm3  = '0;
    for (int k = 0; k < NI; k++) ym[k] = '0;
  endtask

  task automatic cyc(input logic e, input logic d, input logic pl);
    en = e;
    din = d;
    pat_load = pl;
    @(negedge clk);
    if (cidx < 32) begin
      for (int k = 0; k < NI; k++) ym[k][cidx] = y_w[k];
      sm3[cidx] = sat_w[3];
    end
    cidx++;
    @(posedge clk);
    #1;
  endtask

  logic [10:0] s2;

  initial begin
    rst = 1'b0; en = 1'b1; din = 1'b1; pat_load = 1'b0; pin = '0;
    start_rec();
    @(posedge clk); #1;
    started = 1'b1;
    // reset held a second cycle with din=1, en=1
    @(negedge clk);
    chk("t1_y0", 32'(y_w[0]), 0);
    chk("t1_cnt0", 32'(c0), 0);
    chk("t1_sat0", 32'(sat_w[0]), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // default pattern stream, first bit is MSB
    s2 = 11'b11011011101;
    start_rec();
    for (int i = 0; i < 11; i++) cyc(1'b1, s2[10-i], 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t2_ymask", ym[0], 32'h890);
    chk("t2_cnt", 32'(c0), 3);
    chk("t3_ymask", ym[1], 32'h810);
    chk("t3_cnt", 32'(c1), 2);
    chk("t4_ymask", ym[2], 32'h1120);
    chk("t4_cnt", 32'(c2), 3);

    // pattern load clears history; en gap mid-pattern keeps the partial match
    rst = 1'b0; cyc(1'b1, 1'b1, 1'b0); rst = 1'b1;
    pin = 16'h0006;
    start_rec();
    cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t5_ymask", ym[0], 32'h800);
    chk("t5_cnt", 32'(c0), 1);
    chk("t5_moore_ymask", ym[2], 32'h1000);

    // 1111 on a run of ones with a 2-bit counter
    rst = 1'b0; cyc(1'b0, 1'b0, 1'b0); rst = 1'b1;
    start_rec();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("t6_ymask", ym[3], 32'h1F0);
    chk("t6_cnt", 32'(c3), 3);
    chk("t6_sat", 32'(sat_w[3]), 1);
    chk("t6_satmask", sm3, 32'h180);
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    start_rec();
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    chk("t6_rst_y", 32'(ym[3][1]), 0);
    chk("t6_rst_cnt", 32'(c3), 0);
    chk("t6_rst_sat", 32'(sat_w[3]), 0);
    start_rec();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("t6_refill_ymask", ym[3], 32'h10);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 49) == 0) begin
        pin = 16'($urandom);
        cyc(($urandom_range(0, 3) != 0), 1'($urandom), 1'b1);
      end else begin
        cyc(($urandom_range(0, 3) != 0), 1'($urandom), 1'b0);
      end
    end
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
